// File: rtl/hls_seq_datapath_if.sv
// Host-side bundle for the microcoded datapath core.
// Carries program-memory writes, register-file access, the run handshake
// and status back to the host.
//   master : host side (drives strobes, addresses, data, start)
//   slave  : datapath side (returns reg_rdata, busy, done, pc, err)
interface hls_seq_datapath_if #(
  parameter int WIDTH      = 16,
  parameter int NUM_REGS   = 8,
  parameter int PROG_DEPTH = 16
);
  localparam int RA = $clog2(NUM_REGS);
  localparam int PA = $clog2(PROG_DEPTH);
  localparam int IW = 3 + 4 * RA;

  logic             prog_we;
  logic [PA-1:0]    prog_addr;
  logic [IW-1:0]    prog_data;
  logic             reg_we;
  logic [RA-1:0]    reg_addr;
  logic [WIDTH-1:0] reg_wdata;
  logic [WIDTH-1:0] reg_rdata;
  logic             start;
  logic             busy;
  logic             done;
  logic [PA-1:0]    pc;
  logic             err;

  modport master (
    output prog_we, prog_addr, prog_data, reg_we, reg_addr, reg_wdata, start,
    input  reg_rdata, busy, done, pc, err
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, reg_we, reg_addr, reg_wdata, start,
    output reg_rdata, busy, done, pc, err
  );
endinterface

// File: rtl/hls_seq_datapath.sv
// Microcoded execution core: register file, adder, pipelined multiplier and
// 2:1 select unit sequenced by a host-writable program memory.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high
//   host   : hls_seq_datapath_if.slave bundle
//            (prog_we/prog_addr/prog_data  program load,
//             reg_we/reg_addr/reg_wdata/reg_rdata  register access,
//             start/busy/done  run handshake, pc, err  status)
// Instruction word, MSB to LSB: op[2:0], dst, a, b, c (each RA bits).
module hls_seq_datapath #(
  parameter int WIDTH      = 16,
  parameter int NUM_REGS   = 8,
  parameter int PROG_DEPTH = 16,
  parameter int MUL_LAT    = 2
) (
  input logic clk,
  input logic reset,
  hls_seq_datapath_if.slave host
);
  localparam int RA   = $clog2(NUM_REGS);
  localparam int PA   = $clog2(PROG_DEPTH);
  localparam int IW   = 3 + 4 * RA;
  localparam int PA1  = PA + 1;
  localparam int PIPE = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam int CW   = $clog2(MUL_LAT + 1);

  localparam logic [PA-1:0] LAST_PC = PA'(PROG_DEPTH - 1);

  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_SEL  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MULW,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PA-1:0]    pc_q, pc_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]    mul_cnt_q, mul_cnt_d;
  logic [RA-1:0]    mul_dst_q, mul_dst_d;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [WIDTH-1:0] mul_pipe_q [PIPE];
  logic [WIDTH-1:0] mul_pipe_d [PIPE];
  logic [IW-1:0]    prog_mem_q [PROG_DEPTH];

  logic [IW-1:0]    instr;
  logic [2:0]       op_f;
  logic [RA-1:0]    dst_f, a_f, b_f, c_f;
  logic [WIDTH-1:0] a_val, b_val, c_val, host_val;
  logic [WIDTH-1:0] alu_res, mul_prod;
  logic             wr_en, advance, mul_load, host_wr;
  logic [RA-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  // Fetch and field decode of the instruction at the current pc.
  assign instr = prog_mem_q[pc_q];
  assign op_f  = instr[IW-1 -: 3];
  assign dst_f = instr[4*RA-1 -: RA];
  assign a_f   = instr[3*RA-1 -: RA];
  assign b_f   = instr[2*RA-1 -: RA];
  assign c_f   = instr[RA-1:0];

  assign host_wr = host.prog_we | host.reg_we;

  // Register-file read ports. Matching by loop means indices beyond
  // NUM_REGS fall through and read as zero.
  always_comb begin
    a_val    = '0;
    b_val    = '0;
    c_val    = '0;
    host_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a_f == RA'(i))           a_val    = regs_q[i];
      if (b_f == RA'(i))           b_val    = regs_q[i];
      if (c_f == RA'(i))           c_val    = regs_q[i];
      if (host.reg_addr == RA'(i)) host_val = regs_q[i];
    end
  end

  // Single-cycle functional units; the multiply result is truncated to WIDTH.
  always_comb begin
    mul_prod = a_val * b_val;
    case (op_f)
      OP_ADD:  alu_res = a_val + b_val;
      OP_SEL:  alu_res = (c_val != '0) ? b_val : a_val;
      default: alu_res = a_val;
    endcase
  end

  // Sequencer: next state, pc, err and the single register-file write port.
  // Both host writes and instruction results share that write port because
  // they can never occur in the same state.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    err_d     = err_q;
    mul_cnt_d = mul_cnt_q;
    mul_dst_d = mul_dst_q;
    mul_load  = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = dst_f;
    wr_data   = alu_res;
    advance   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (host.reg_we) begin
          wr_en   = 1'b1;
          wr_addr = host.reg_addr;
          wr_data = host.reg_wdata;
        end
        if (host.start) begin
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (host_wr) err_d = 1'b1;
        case (op_f)
          OP_MOV, OP_ADD, OP_SEL: begin
            wr_en   = 1'b1;
            advance = 1'b1;
          end
          OP_MUL: begin
            if (MUL_LAT == 1) begin
              wr_en   = 1'b1;
              wr_data = mul_prod;
              advance = 1'b1;
            end else begin
              mul_load  = 1'b1;
              mul_dst_d = dst_f;
              mul_cnt_d = '0;
              state_d   = ST_MULW;
            end
          end
          OP_HALT: state_d = ST_DONE;
          default: advance = 1'b1;
        endcase
      end
      ST_MULW: begin
        if (host_wr) err_d = 1'b1;
        if (mul_cnt_q == CW'(MUL_LAT - 2)) begin
          wr_en   = 1'b1;
          wr_addr = mul_dst_q;
          wr_data = mul_pipe_q[PIPE-1];
          advance = 1'b1;
        end else begin
          mul_cnt_d = mul_cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The last program address finishes the run instead of wrapping.
    if (advance) begin
      if (pc_q == LAST_PC) begin
        state_d = ST_DONE;
      end else begin
        pc_d    = pc_q + PA'(1);
        state_d = ST_EXEC;
      end
    end
  end

  // Register-file update; a write to an index beyond NUM_REGS matches no
  // entry and is dropped.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (wr_addr == RA'(i))) regs_d[i] = wr_data;
    end
  end

  // Multiplier pipeline: the product enters stage 0 when a MUL issues and
  // ripples down one stage per cycle, arriving at the last stage exactly
  // on the final MULW cycle.
  always_comb begin
    for (int i = 0; i < PIPE; i++) mul_pipe_d[i] = mul_pipe_q[i];
    if (mul_load) mul_pipe_d[0] = mul_prod;
    for (int i = 1; i < PIPE; i++) mul_pipe_d[i] = mul_pipe_q[i-1];
  end

  // Host read port samples the pre-write contents, so a same-cycle write
  // to the same address returns the old value.
  assign rdata_d = host_val;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      mul_cnt_q <= '0;
      mul_dst_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      for (int i = 0; i < PIPE; i++) mul_pipe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      mul_cnt_q <= mul_cnt_d;
      mul_dst_q <= mul_dst_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      for (int i = 0; i < PIPE; i++) mul_pipe_q[i] <= mul_pipe_d[i];
    end
  end

  // Program memory has no reset; it is only writable while idle.
  always_ff @(posedge clk) begin
    if (host.prog_we && (state_q == ST_IDLE) &&
        ({1'b0, host.prog_addr} < PA1'(PROG_DEPTH))) begin
      prog_mem_q[host.prog_addr] <= host.prog_data;
    end
  end

  assign host.busy      = (state_q == ST_EXEC) || (state_q == ST_MULW);
  assign host.done      = (state_q == ST_DONE);
  assign host.pc        = pc_q;
  assign host.err       = err_q;
  assign host.reg_rdata = rdata_q;
endmodule

// File: tb/tb_hls_seq_datapath.sv
// Testbench for hls_seq_datapath: directed scenarios plus randomized
// programs compared against an instruction-level reference model.
module tb_hls_seq_datapath;
  localparam int WIDTH      = 16;
  localparam int NUM_REGS   = 8;
  localparam int PROG_DEPTH = 16;
  localparam int MUL_LAT    = 2;
  localparam int IW         = 15;
  localparam int MAX_CYC    = 200;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [IW-1:0]    m_prog [PROG_DEPTH];
  logic [WIDTH-1:0] m_regs [NUM_REGS];

  hls_seq_datapath_if #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .PROG_DEPTH(PROG_DEPTH)) bus ();

  hls_seq_datapath #(
    .WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .PROG_DEPTH(PROG_DEPTH), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .host (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] enc(input int op, input int dst, input int a,
                                        input int b, input int c);
    return {3'(op), 3'(dst), 3'(a), 3'(b), 3'(c)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_idle();
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.reg_we    = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;
    bus.start     = 1'b0;
  endtask

  task automatic write_reg(input int addr, input logic [WIDTH-1:0] data);
    bus.reg_we    = 1'b1;
    bus.reg_addr  = 3'(addr);
    bus.reg_wdata = data;
    tick();
    bus.reg_we    = 1'b0;
    m_regs[addr]  = data;
  endtask

  task automatic read_reg(input int addr, output logic [WIDTH-1:0] data);
    bus.reg_addr = 3'(addr);
    tick();
    data = bus.reg_rdata;
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = 4'(i);
      bus.prog_data = m_prog[i];
      tick();
    end
    bus.prog_we = 1'b0;
  endtask

  // Instruction-level model: walks the program, applies each opcode's
  // arithmetic to m_regs and totals per-instruction cycle costs.
  task automatic model_run(output int cycles, output int busy_cycles, output int end_pc);
    int pc, cost, op, dst, a, b, c;
    int unsigned x, y;
    pc   = 0;
    cost = 0;
    forever begin
      op  = int'(m_prog[pc]) >> 12;
      dst = (int'(m_prog[pc]) >> 9) & 7;
      a   = (int'(m_prog[pc]) >> 6) & 7;
      b   = (int'(m_prog[pc]) >> 3) & 7;
      c   = int'(m_prog[pc]) & 7;
      x   = m_regs[a];
      y   = m_regs[b];
      if (op == 7) begin
        cost += 1;
        break;
      end
      case (op)
        1: m_regs[dst] = WIDTH'(x);
        2: m_regs[dst] = WIDTH'((x + y) % 65536);
        3: m_regs[dst] = WIDTH'((x * y) % 65536);
        4: m_regs[dst] = (m_regs[c] != 0) ? WIDTH'(y) : WIDTH'(x);
        default: ;
      endcase
      cost += (op == 3) ? MUL_LAT : 1;
      if (pc == PROG_DEPTH - 1) break;
      pc++;
    end
    cycles      = cost + 2;
    busy_cycles = cost;
    end_pc      = pc;
  endtask

  // Pulses start and waits (bounded) for done. cycles counts the start
  // cycle as 1 through the done cycle inclusive. With inject set, a
  // register write and a second start are driven during the run.
  task automatic run_dut(input bit inject, output int cycles, output int busy_cycles,
                         output int end_pc);
    bus.start = 1'b1;
    tick();
    bus.start   = 1'b0;
    cycles      = 2;
    busy_cycles = 0;
    while (bus.done !== 1'b1 && cycles < MAX_CYC) begin
      if (bus.busy === 1'b1) busy_cycles++;
      if (inject && cycles == 2) begin
        bus.reg_we    = 1'b1;
        bus.reg_addr  = 3'd1;
        bus.reg_wdata = 16'd99;
        bus.start     = 1'b1;
      end
      tick();
      cycles++;
      bus.reg_we = 1'b0;
      bus.start  = 1'b0;
    end
    end_pc = int'(bus.pc);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL run_timeout: done=%b after %0d cycles, required done=1", bus.done, cycles);
    end
    tick();
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] v;
    host_idle();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    checks++;
    if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_status: busy/done/err=%b required 000", {bus.busy, bus.done, bus.err});
    end
    checks++;
    if (bus.pc !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_pc: got %0d required 0", bus.pc);
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      read_reg(i, v);
      checks++;
      if (v !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL reset_reg%0d: got %h required 0000", i, v);
      end
    end
  endtask

  task automatic test_read_old();
    logic [WIDTH-1:0] v;
    write_reg(7, 16'hAAAA);
    write_reg(7, 16'h5555);
    checks++;
    if (bus.reg_rdata !== 16'hAAAA) begin
      errors++;
      $display("[TB] FAIL read_during_write: got %h required aaaa", bus.reg_rdata);
    end
    read_reg(7, v);
    checks++;
    if (v !== 16'h5555) begin
      errors++;
      $display("[TB] FAIL read_after_write: got %h required 5555", v);
    end
  endtask

  task automatic test_add_mov();
    int cyc, bcyc, epc, mc, mb, mp;
    logic [WIDTH-1:0] v;
    write_reg(1, 16'd5);
    write_reg(2, 16'd7);
    m_prog[0] = enc(2, 3, 1, 2, 0);
    m_prog[1] = enc(1, 4, 3, 0, 0);
    m_prog[2] = enc(7, 0, 0, 0, 0);
    load_prog(3);
    model_run(mc, mb, mp);
    run_dut(1'b0, cyc, bcyc, epc);
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("[TB] FAIL add_mov_latency: got %0d cycles required 5", cyc);
    end
    read_reg(3, v);
    checks++;
    if (v !== 16'd12) begin
      errors++;
      $display("[TB] FAIL add_r3: got %0d required 12", v);
    end
    read_reg(4, v);
    checks++;
    if (v !== 16'd12) begin
      errors++;
      $display("[TB] FAIL mov_r4: got %0d required 12", v);
    end
  endtask

  task automatic test_mul_wrap();
    int cyc, bcyc, epc, mc, mb, mp;
    logic [WIDTH-1:0] v;
    write_reg(1, 16'h0100);
    write_reg(2, 16'h0101);
    m_prog[0] = enc(3, 3, 1, 2, 0);
    m_prog[1] = enc(7, 0, 0, 0, 0);
    load_prog(2);
    model_run(mc, mb, mp);
    run_dut(1'b0, cyc, bcyc, epc);
    checks++;
    if (bcyc !== 3) begin
      errors++;
      $display("[TB] FAIL mul_busy_cycles: got %0d required 3", bcyc);
    end
    read_reg(3, v);
    checks++;
    if (v !== 16'h0100) begin
      errors++;
      $display("[TB] FAIL mul_result: got %h required 0100", v);
    end
    write_reg(1, 16'hFFFF);
    write_reg(2, 16'h0002);
    m_prog[0] = enc(2, 3, 1, 2, 0);
    load_prog(1);
    run_dut(1'b0, cyc, bcyc, epc);
    read_reg(3, v);
    checks++;
    if (v !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL add_wrap: got %h required 0001", v);
    end
  endtask

  task automatic test_sel();
    int cyc, bcyc, epc;
    logic [WIDTH-1:0] v;
    write_reg(1, 16'h1111);
    write_reg(2, 16'h2222);
    write_reg(5, 16'h0000);
    m_prog[0] = enc(4, 6, 1, 2, 5);
    m_prog[1] = enc(7, 0, 0, 0, 0);
    load_prog(2);
    run_dut(1'b0, cyc, bcyc, epc);
    read_reg(6, v);
    checks++;
    if (v !== 16'h1111) begin
      errors++;
      $display("[TB] FAIL sel_zero: got %h required 1111", v);
    end
    write_reg(5, 16'h0003);
    run_dut(1'b0, cyc, bcyc, epc);
    read_reg(6, v);
    checks++;
    if (v !== 16'h2222) begin
      errors++;
      $display("[TB] FAIL sel_nonzero: got %h required 2222", v);
    end
  endtask

  task automatic test_busy_violation();
    int cyc, bcyc, epc, mc, mb, mp;
    logic [WIDTH-1:0] v;
    write_reg(1, 16'd3);
    write_reg(2, 16'd4);
    m_prog[0] = enc(2, 3, 1, 2, 0);
    m_prog[1] = enc(3, 4, 1, 2, 0);
    m_prog[2] = enc(0, 0, 0, 0, 0);
    m_prog[3] = enc(7, 0, 0, 0, 0);
    load_prog(4);
    model_run(mc, mb, mp);
    run_dut(1'b1, cyc, bcyc, epc);
    checks++;
    if (cyc !== mc) begin
      errors++;
      $display("[TB] FAIL busy_viol_cycles: got %0d required %0d", cyc, mc);
    end
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_viol_err: got %b required 1", bus.err);
    end
    read_reg(1, v);
    checks++;
    if (v !== m_regs[1]) begin
      errors++;
      $display("[TB] FAIL busy_viol_r1: got %0d required %0d", v, m_regs[1]);
    end
    read_reg(4, v);
    checks++;
    if (v !== m_regs[4]) begin
      errors++;
      $display("[TB] FAIL busy_viol_r4: got %0d required %0d", v, m_regs[4]);
    end
    run_dut(1'b0, cyc, bcyc, epc);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_cleared: got %b required 0", bus.err);
    end
  endtask

  task automatic test_last_address();
    int cyc, bcyc, epc;
    for (int i = 0; i < PROG_DEPTH; i++) m_prog[i] = enc(0, 0, 0, 0, 0);
    load_prog(PROG_DEPTH);
    run_dut(1'b0, cyc, bcyc, epc);
    checks++;
    if (epc !== 15) begin
      errors++;
      $display("[TB] FAIL last_addr_pc: got %0d required 15", epc);
    end
    checks++;
    if (cyc !== 18) begin
      errors++;
      $display("[TB] FAIL last_addr_cycles: got %0d required 18", cyc);
    end
  endtask

  task automatic test_reset_abort();
    logic [WIDTH-1:0] v;
    bit saw_done;
    write_reg(1, 16'h1234);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL abort_status: busy/done=%b required 00", {bus.busy, bus.done});
    end
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got done pulse required none");
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      read_reg(i, v);
      checks++;
      if (v !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL abort_reg%0d: got %h required 0000", i, v);
      end
    end
  endtask

  task automatic test_random();
    int cyc, bcyc, epc, mc, mb, mp;
    logic [WIDTH-1:0] v;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < NUM_REGS; i++) write_reg(i, WIDTH'($urandom));
      for (int i = 0; i < PROG_DEPTH; i++)
        m_prog[i] = enc($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7), $urandom_range(0, 7));
      load_prog(PROG_DEPTH);
      model_run(mc, mb, mp);
      run_dut(1'b0, cyc, bcyc, epc);
      checks++;
      if (cyc !== mc || bcyc !== mb) begin
        errors++;
        $display("[TB] FAIL rand%0d_timing: got cycles=%0d busy=%0d required cycles=%0d busy=%0d",
                 it, cyc, bcyc, mc, mb);
      end
      checks++;
      if (epc !== mp) begin
        errors++;
        $display("[TB] FAIL rand%0d_pc: got %0d required %0d", it, epc, mp);
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        read_reg(i, v);
        checks++;
        if (v !== m_regs[i]) begin
          errors++;
          $display("[TB] FAIL rand%0d_reg%0d: got %h required %h", it, i, v, m_regs[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_old();
    test_add_mov();
    test_mul_wrap();
    test_sel();
    test_busy_violation();
    test_last_address();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
